// File: rtl/s2qed_pkg.sv
// Shared definitions for the S2QED dual-issue dispatcher: RV32 opcode/funct
// constants, the dispatcher state encoding and the register-renaming function.
package s2qed_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // x0 stays fixed; x1..x12 and x13..x31 are each mirrored within their bank.
  function automatic logic [4:0] reg_map(input logic [4:0] r);
    if (r == 5'd0)
      return 5'd0;
    else if (r <= 5'd12)
      return 5'd13 - r;
    else
      return 5'(6'd44 - {1'b0, r});
  endfunction

endpackage

// File: rtl/s2qed_inst_map.sv
// Combinational legality check and register remapping of one RV32 instruction
// for the duplicate core.
module s2qed_inst_map
  import s2qed_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_mapped,
  output logic        o_legal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_op;
  logic       w_is_imm;
  logic       w_f7_zero;
  logic       w_f7_alt;
  logic [4:0] w_rs2_out;

  assign w_opcode  = i_inst[6:0];
  assign w_funct3  = i_inst[14:12];
  assign w_funct7  = i_inst[31:25];
  assign w_is_op   = (w_opcode == OPC_OP);
  assign w_is_imm  = (w_opcode == OPC_OP_IMM);
  assign w_f7_zero = (w_funct7 == F7_ZERO);
  assign w_f7_alt  = (w_funct7 == F7_ALT);

  always_comb begin
    o_legal = 1'b0;
    if (w_is_imm) begin
      case (w_funct3)
        F3_SLL:     o_legal = w_f7_zero;
        F3_SRL_SRA: o_legal = w_f7_zero | w_f7_alt;
        F3_ADD_SUB, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: o_legal = 1'b1;
      endcase
    end else if (w_is_op) begin
      case (w_funct3)
        F3_ADD_SUB, F3_SRL_SRA: o_legal = w_f7_zero | w_f7_alt;
        F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: o_legal = w_f7_zero;
      endcase
    end
  end

  // For OP-IMM bits [24:20] belong to the immediate and must pass through.
  assign w_rs2_out = w_is_op ? reg_map(i_inst[24:20]) : i_inst[24:20];

  assign o_mapped = {i_inst[31:25], w_rs2_out, reg_map(i_inst[19:15]),
                     i_inst[14:12], reg_map(i_inst[11:7]), i_inst[6:0]};

endmodule

// File: rtl/s2qed_dispatch.sv
// Dual-issue dispatcher: sends an instruction and its register-renamed twin to
// two cores, waits for both to retire, and flags excessive retirement skew.
module s2qed_dispatch
  import s2qed_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             src_valid,
  input  logic [31:0]      src_inst,
  output logic             src_ready,
  output logic [31:0]      cpu0_inst,
  output logic [31:0]      cpu1_inst,
  output logic             cpu0_req,
  output logic             cpu1_req,
  input  logic             cpu0_ack,
  input  logic             cpu1_ack,
  output logic             illegal,
  output logic             timeout_err,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [1:0]       dbg_state
);

  // Handshakes: src_inst transfers on a clock edge where src_valid && src_ready.
  // cpuN_req stays high until cpuN_ack is sampled with it; ack without req is ignored.

  localparam int SKEW_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [31:0]       r_cpu0_inst;
  logic [31:0]       r_cpu1_inst;
  logic              r_req0;
  logic              r_req1;
  logic              r_seen0;
  logic              r_seen1;
  logic              r_illegal;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic [SKEW_W-1:0] r_skew;

  logic [31:0]       w_mapped;
  logic              w_legal;
  logic              w_take0;
  logic              w_take1;
  logic              w_both;
  logic              w_one;
  logic [SKEW_W-1:0] w_skew_inc;
  logic              w_ready;

  s2qed_inst_map u_map (
    .i_inst   (src_inst),
    .o_mapped (w_mapped),
    .o_legal  (w_legal)
  );

  assign w_take0    = r_req0 & cpu0_ack;
  assign w_take1    = r_req1 & cpu1_ack;
  assign w_both     = (r_seen0 | w_take0) & (r_seen1 | w_take1);
  assign w_one      = r_seen0 ^ r_seen1;
  assign w_skew_inc = r_skew + SKEW_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (src_valid && w_legal) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A completing second ack wins over a skew expiry in the same cycle.
        if (w_both)
          w_state_nxt = ST_DONE;
        else if (w_one && (w_skew_inc == SKEW_LAST))
          w_state_nxt = ST_ERROR;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_state_nxt = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cpu0_inst <= '0;
      r_cpu1_inst <= '0;
      r_req0      <= 1'b0;
      r_req1      <= 1'b0;
      r_seen0     <= 1'b0;
      r_seen1     <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_skew      <= '0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (src_valid) begin
            if (w_legal) begin
              r_cpu0_inst <= src_inst;
              r_cpu1_inst <= w_mapped;
              r_req0      <= 1'b1;
              r_req1      <= 1'b1;
              r_seen0     <= 1'b0;
              r_seen1     <= 1'b0;
              r_skew      <= '0;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_take0) begin
            r_req0  <= 1'b0;
            r_seen0 <= 1'b1;
          end
          if (w_take1) begin
            r_req1  <= 1'b0;
            r_seen1 <= 1'b1;
          end
          if (w_one) r_skew <= w_skew_inc;
          if (w_state_nxt == ST_ERROR) begin
            r_req0    <= 1'b0;
            r_req1    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_seen0 <= 1'b0;
          r_seen1 <= 1'b0;
          r_skew  <= '0;
        end
        ST_ERROR: ;
      endcase
    end
  end

  assign src_ready   = w_ready;
  assign cpu0_inst   = r_cpu0_inst;
  assign cpu1_inst   = r_cpu1_inst;
  assign cpu0_req    = r_req0;
  assign cpu1_req    = r_req1;
  assign illegal     = r_illegal;
  assign timeout_err = r_timeout;
  assign busy        = (r_state != ST_IDLE);
  assign issued_cnt  = r_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_s2qed_dispatch.sv
// Directed and randomized bench for s2qed_dispatch with a small TIMEOUT and a
// 2-bit issue counter so skew expiry and counter wrap are reachable quickly.
module tb_s2qed_dispatch;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             src_valid = 1'b0;
  logic [31:0]      src_inst = '0;
  logic             src_ready;
  logic [31:0]      cpu0_inst;
  logic [31:0]      cpu1_inst;
  logic             cpu0_req;
  logic             cpu1_req;
  logic             cpu0_ack = 1'b0;
  logic             cpu1_ack = 1'b0;
  logic             illegal;
  logic             timeout_err;
  logic             busy;
  logic [CNT_W-1:0] issued_cnt;
  logic [1:0]       dbg_state;

  int               checks = 0;
  int               failures = 0;
  logic [63:0]      exp_q[$];
  logic [63:0]      last_exp = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  s2qed_dispatch #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .src_valid   (src_valid),
    .src_inst    (src_inst),
    .src_ready   (src_ready),
    .cpu0_inst   (cpu0_inst),
    .cpu1_inst   (cpu1_inst),
    .cpu0_req    (cpu0_req),
    .cpu1_req    (cpu1_req),
    .cpu0_ack    (cpu0_ack),
    .cpu1_ack    (cpu1_ack),
    .illegal     (illegal),
    .timeout_err (timeout_err),
    .busy        (busy),
    .issued_cnt  (issued_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_map(input logic [4:0] r);
    if (r == 5'd0) return 5'd0;
    if (r < 5'd13) return 5'(13 - int'(r));
    return 5'(44 - int'(r));
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] i);
    logic [31:0] m;
    m        = i;
    m[11:7]  = model_map(i[11:7]);
    m[19:15] = model_map(i[19:15]);
    if (i[6:0] == 7'b0110011) m[24:20] = model_map(i[24:20]);
    return m;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] i;
    logic [2:0]  f3;
    i     = $urandom;
    f3    = 3'($urandom_range(0, 7));
    i[14:12] = f3;
    if ($urandom_range(0, 1) == 1) begin
      i[6:0]   = 7'b0110011;
      i[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
    end else begin
      i[6:0] = 7'b0010011;
      if (f3 == 3'd1) i[31:25] = 7'b0;
      else if (f3 == 3'd5) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
    end
    return i;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_reset_values();
    check("rst_state", dbg_state, S_IDLE);
    check("rst_ready", src_ready, 1);
    check("rst_req0", cpu0_req, 0);
    check("rst_req1", cpu1_req, 0);
    check("rst_inst0", cpu0_inst, 0);
    check("rst_inst1", cpu1_inst, 0);
    check("rst_illegal", illegal, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_cnt", issued_cnt, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic dispatch(input logic [31:0] inst, input logic [31:0] exp1);
    logic [63:0] e;
    exp_q.push_back({inst, exp1});
    check("ready_before", src_ready, 1);
    src_valid = 1'b1;
    src_inst  = inst;
    @(negedge clk);
    src_valid = 1'b0;
    src_inst  = $urandom;
    check("req0_up", cpu0_req, 1);
    check("req1_up", cpu1_req, 1);
    check("ready_issue", src_ready, 0);
    check("issue_state", dbg_state, S_ISSUE);
    check("no_illegal", illegal, 0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e        = exp_q.pop_front();
      last_exp = e;
      check("cpu0_inst", cpu0_inst, e[63:32]);
      check("cpu1_inst", cpu1_inst, e[31:0]);
    end
  endtask

  task automatic send_illegal(input logic [31:0] inst);
    check("ready_before_ill", src_ready, 1);
    src_valid = 1'b1;
    src_inst  = inst;
    @(negedge clk);
    src_valid = 1'b0;
    check("illegal_pulse", illegal, 1);
    check("ill_req0", cpu0_req, 0);
    check("ill_req1", cpu1_req, 0);
    check("ill_idle", dbg_state, S_IDLE);
    check("ill_cnt", issued_cnt, exp_cnt);
    @(negedge clk);
    check("illegal_drop", illegal, 0);
  endtask

  task automatic finish_done();
    check("done_state", dbg_state, S_DONE);
    check("done_req0", cpu0_req, 0);
    check("done_req1", cpu1_req, 0);
    check("done_busy", busy, 1);
    check("done_ready", src_ready, 0);
    check("done_cnt_old", issued_cnt, exp_cnt);
    @(negedge clk);
    exp_cnt++;
    check("cnt_after", issued_cnt, exp_cnt);
    check("ready_back", src_ready, 1);
    check("idle_back", dbg_state, S_IDLE);
  endtask

  task automatic ack_both();
    cpu0_ack = 1'b1;
    cpu1_ack = 1'b1;
    @(negedge clk);
    cpu0_ack = 1'b0;
    cpu1_ack = 1'b0;
    finish_done();
  endtask

  task automatic ack_first(input bit first1);
    if (first1) cpu1_ack = 1'b1;
    else        cpu0_ack = 1'b1;
    @(negedge clk);
    cpu0_ack = 1'b0;
    cpu1_ack = 1'b0;
    check("first_req_drop", first1 ? cpu1_req : cpu0_req, 0);
    check("other_req_held", first1 ? cpu0_req : cpu1_req, 1);
    check("issue_hold", dbg_state, S_ISSUE);
    check("inst_stable", {cpu0_inst, cpu1_inst}, last_exp);
  endtask

  task automatic ack_staggered(input bit first1, input int gap);
    ack_first(first1);
    repeat (gap) begin
      if (first1) cpu1_ack = 1'b1;
      else        cpu0_ack = 1'b1;
      @(negedge clk);
    end
    cpu0_ack = 1'b0;
    cpu1_ack = 1'b0;
    check("still_issue", dbg_state, S_ISSUE);
    check("inst_stable2", {cpu0_inst, cpu1_inst}, last_exp);
    if (first1) cpu0_ack = 1'b1;
    else        cpu1_ack = 1'b1;
    @(negedge clk);
    cpu0_ack = 1'b0;
    cpu1_ack = 1'b0;
    finish_done();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] inst;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rstn = 1'b1;
    @(negedge clk);

    // Rejected encodings: load, OP sll with funct7=0100000, OP-IMM slli with funct7=1.
    send_illegal(32'h0000_2003);
    send_illegal(32'h4000_1033);
    send_illegal(32'h0200_1013);
    check("cnt_after_illegal", issued_cnt, 0);

    dispatch(32'h0031_00B3, 32'h00A5_8633);
    ack_both();

    dispatch(32'h0050_0693, 32'h0050_0F93);
    ack_staggered(1'b0, 2);

    dispatch(32'h4050_5093, model_inst(32'h4050_5093));
    ack_staggered(1'b1, 1);
    check("cnt_before_wrap", issued_cnt, 3);

    dispatch(32'h4031_00B3, model_inst(32'h4031_00B3));
    ack_both();
    check("cnt_wrapped", issued_cnt, 0);

    // Acks with no request outstanding must not move the FSM.
    cpu0_ack = 1'b1;
    cpu1_ack = 1'b1;
    repeat (2) @(negedge clk);
    cpu0_ack = 1'b0;
    cpu1_ack = 1'b0;
    check("ack_ignored_state", dbg_state, S_IDLE);
    check("ack_ignored_cnt", issued_cnt, exp_cnt);

    for (int n = 0; n < 6; n++) begin
      inst = rand_legal();
      dispatch(inst, model_inst(inst));
      if ($urandom_range(0, 2) == 0) ack_both();
      else ack_staggered(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset in the middle of an issue abandons it.
    inst = rand_legal();
    dispatch(inst, model_inst(inst));
    ack_first(1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rstn    = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    inst = rand_legal();
    dispatch(inst, model_inst(inst));
    ack_both();
    check("cnt_after_reset_issue", issued_cnt, 1);

    // Skew timeout: cpu0 acks two cycles after req, cpu1 never does.
    inst = rand_legal();
    dispatch(inst, model_inst(inst));
    repeat (2) @(negedge clk);
    cpu0_ack = 1'b1;
    @(negedge clk);
    cpu0_ack = 1'b0;
    check("to_req0_low", cpu0_req, 0);
    check("to_req1_high", cpu1_req, 1);
    repeat (6) @(negedge clk);
    check("to_not_yet", timeout_err, 0);
    check("to_issue_7", dbg_state, S_ISSUE);
    @(negedge clk);
    check("to_flag", timeout_err, 1);
    check("to_state", dbg_state, S_ERROR);
    check("to_req0", cpu0_req, 0);
    check("to_req1", cpu1_req, 0);
    check("to_ready", src_ready, 0);

    // ERROR ignores everything.
    src_valid = 1'b1;
    src_inst  = 32'h0031_00B3;
    cpu0_ack  = 1'b1;
    cpu1_ack  = 1'b1;
    repeat (4) @(negedge clk);
    src_valid = 1'b0;
    cpu0_ack  = 1'b0;
    cpu1_ack  = 1'b0;
    check("err_sticky", timeout_err, 1);
    check("err_state", dbg_state, S_ERROR);
    check("err_ready", src_ready, 0);
    check("err_req0", cpu0_req, 0);
    check("err_req1", cpu1_req, 0);
    check("err_cnt", issued_cnt, exp_cnt);
    check("err_illegal", illegal, 0);

    #2 rstn = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rstn    = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    dispatch(32'h0031_00B3, 32'h00A5_8633);
    ack_both();
    check("scoreboard_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2qed_dispatch.md
S2QED_DISPATCH -- requirements
Module: s2qed_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum number of cycles allowed between the first and the second core ack.
REQ-002 SHALL have parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port src_valid, input, 1: a candidate instruction is present.
REQ-006 SHALL have port src_inst, input, 32: the candidate RV32 instruction.
REQ-007 SHALL have port src_ready, output, 1: the dispatcher accepts src_inst this cycle.
REQ-008 SHALL have ports cpu0_inst and cpu1_inst, output, 32 each: original instruction and register-mapped instruction.
REQ-009 SHALL have ports cpu0_req and cpu1_req, output, 1 each: instruction offered to the core.
REQ-010 SHALL have ports cpu0_ack and cpu1_ack, input, 1 each: the core has retired the offered instruction.
REQ-011 SHALL have port illegal, output, 1: one-cycle pulse when a rejected instruction is consumed.
REQ-012 SHALL have port timeout_err, output, 1: sticky skew-timeout flag.
REQ-013 SHALL have port busy, output, 1: the state is not IDLE.
REQ-014 SHALL have port issued_cnt, output, CNT_W: count of completed dual issues.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DONE and ERROR.
REQ-016 SHALL drive src_ready=1 only in IDLE.
REQ-017 SHALL treat an instruction as legal only when all of the following hold:
- opcode is OP (0110011) or OP_IMM (0010011);
- OP_IMM with funct3 SLL has funct7=0;
- OP_IMM with funct3 SRL/SRA has funct7 equal to 0 or 0100000;
- OP with funct3 SLL/SLT/SLTU/XOR/OR/AND has funct7=0;
- OP with funct3 ADD/SUB or SRL/SRA has funct7 equal to 0 or 0100000.
REQ-018 SHALL, in IDLE on src_valid with an illegal instruction, consume it, pulse illegal in the next cycle, and stay in IDLE.
REQ-019 SHALL, in IDLE on src_valid with a legal instruction, register both instructions and enter ISSUE, so that the reqs go high in the cycle after the handshake.
REQ-020 SHALL form cpu1_inst from src_inst with rd and rs1 remapped, and rs2 remapped only for OP; OP_IMM immediate bits [31:20] SHALL pass unchanged.
REQ-021 SHALL use the register map 0->0, r in 1..12 -> 13-r, r in 13..31 -> 44-r.
REQ-022 SHALL hold cpuN_inst stable while in ISSUE.
REQ-023 SHALL, in ISSUE, hold cpuN_req high until cpuN_ack is sampled, then drop it in the next cycle and latch ackN_seen.
REQ-024 SHALL ignore cpuN_ack while cpuN_req is low.
REQ-025 SHALL move ISSUE->DONE when both ackN_seen are set; simultaneous acks in the same cycle qualify.
REQ-026 SHALL, in DONE (one cycle), increment issued_cnt with wrap-around and then return to IDLE.
REQ-027 SHALL start a skew counter when exactly one ackN_seen is set; reaching TIMEOUT-1 SHALL move to ERROR.
REQ-028 SHALL, in ERROR, hold both reqs low, hold timeout_err=1, ignore all inputs, and exit only on reset.

Reset
REQ-029 SHALL, while rstn=0, asynchronously force state=IDLE, all reqs=0, cpu0_inst=cpu1_inst=0, illegal=0, timeout_err=0, issued_cnt=0, the skew counter=0, and all ackN_seen=0.
REQ-030 SHALL, on reset during ISSUE, abandon the in-flight instruction without a completion count.

Structure
REQ-031 SHALL place the opcode and funct3 constants, the state enum, and the reg_map function in the shared package s2qed_pkg.
REQ-032 SHALL implement the combinational mapping and legality check in sub-module s2qed_inst_map.

Verification
REQ-033 Scenario: src_inst=0x003100B3 (add x1,x2,x3) -> cpu0_inst=0x003100B3 and cpu1_inst=0x00A58633, with reqs high one cycle after the handshake.
REQ-034 Scenario: src_inst=0x00500693 (addi x13,x0,5) -> cpu1_inst=0x00500F93, immediate unchanged.
REQ-035 Scenario: src_inst=0x00002003 (load), then 0x40001033 (sll with funct7 0100000) -> one illegal pulse each, no reqs, issued_cnt stays 0.
REQ-036 Scenario: both acks in the same cycle k -> DONE in k+1, issued_cnt 0->1, src_ready=1 in k+2; with CNT_W=2 and issued_cnt=3, a completion wraps it to 0.
REQ-037 Scenario: TIMEOUT=8, cpu0_ack 2 cycles after req and cpu1_ack never -> timeout_err=1 eight cycles after cpu0_ack, reqs low, src_ready stays 0.
REQ-038 Scenario: rstn low mid-ISSUE after cpu0_ack -> all outputs at reset values; after release a fresh instruction dispatches normally.
